board_renderer: RTL
===================

// Module: board_renderer
// PURPOSE
//   Downstream of the game datapath. Takes the nine 2-bit square registers (s1..s9) and redraws the
//   3x3 board into the 160x120, 3-bit colour VGA adapter.
//   Draws one pixel per clock on the vga_adapter x/y/colour/plot interface, with grid lines,
//   red X glyphs and blue O box glyphs.
//   Triggered by the control FSM's draw step. Reports busy/done so the FSM can wait on it.
// PARAMETERS
//   CELL_LOG2   5       log2 of the cell edge in pixels (cell = 32, grid = 96x96)
//   X0          32      screen x of grid pixel (0,0)
//   Y0          12      screen y of grid pixel (0,0)
//   MARGIN      4       glyph inset from cell edge, in pixels
// PORTS
//   clock       in   1   system clock (CLOCK_50)
//   resetn      in   1   reset, asynchronous, ACTIVE-HIGH (despite the name)
//   start       in   1   request a full board redraw; sampled in IDLE only
//   board       in   18  {s9,...,s1}; cell k+1 = board[2k+1:2k]; 01=X, 10=O, 00/11=empty
//   x           out  8   screen x = X0 + px
//   y           out  7   screen y = Y0 + py
//   colour      out  3   RGB: line 111, X 100, O 001, background 000
//   plot        out  1   pixel write strobe to vga_adapter
//   busy        out  1   high from start acceptance until done
//   done        out  1   single-cycle pulse when the sweep has finished
// BEHAVIOUR
//   Reset (async, resetn=1):
//     - FSM goes to IDLE.
//     - x=0, y=0, colour=0, plot=0, busy=0, done=0.
//     - Counters and board snapshot are cleared.
//     - Reset asserted mid-sweep drops plot in the same cycle; no further pixels are written.
//   FSM IDLE -> DRAW -> DONE -> IDLE:
//     - IDLE: on start=1 at edge N, latch board into snap, clear px/py, set busy=1, enter DRAW.
//     - DRAW: the sweep counter runs py outer, px inner, each over 0..95.
//       px increments every cycle; px wrap 95->0 increments py.
//       After pixel (95,95) the FSM enters DONE.
//     - DONE: one cycle, done=1, busy=0, plot=0; then IDLE.
//   Timing:
//     - Outputs are registered, one-stage pipeline from the counters.
//     - The first pixel (0,0) has plot=1 after edge N+1.
//     - The last pixel (95,95) is after edge N+9216.
//     - done=1 after edge N+9217.
//     - Exactly 9216 plot cycles per redraw.
//   start handling:
//     - start while busy or in DONE is ignored; it is not queued.
//     - start held high re-triggers at the next IDLE cycle.
//   board handling:
//     - board changes during a sweep are ignored; only snap is rendered.
//   Pixel classification (per cycle):
//     - Coordinates: col = px>>CELL_LOG2, row = py>>CELL_LOG2, u = px[4:0], v = py[4:0], C = 32.
//     - Cell index = row*3 + col; sym = snap[2*idx+1 : 2*idx].
//     - Priority order:
//       1. Line: (col>0 && u==0) || (row>0 && v==0) -> 111. There is no outer border.
//       2. X glyph: sym==01, u and v in [MARGIN, C-1-MARGIN], and (|u-v|<=1 || |u+v-(C-1)|<=1) -> 100.
//       3. O glyph: sym==10, u and v in [MARGIN, C-1-MARGIN], and (u or v equals MARGIN or C-1-MARGIN) -> 001.
//       4. Otherwise 000. Codes 00 and 11 render as empty.
//   Width rules: x = X0 + px (8-bit), y = Y0 + py (7-bit); no overflow with the defaults.
// TESTING
//   1. Assert resetn, release, wait 10 cycles -> plot=0, busy=0, done=0, x=y=colour=0.
//   2. Empty board, pulse start -> exactly 9216 plot cycles then one done pulse.
//      Pixel (x=64,y=17) is 111; pixel (x=36,y=16) is 000.
//   3. board[1:0]=01 (X in s1), start -> (36,16) is 100, (48,28) is 100, (48,16) is 000.
//   4. board[17:16]=10 (O in s9), start -> (100,86) is 001; the cell centre (112,92) is 000.
//   5. Pulse start again mid-sweep and flip board bits -> the sweep is not restarted,
//      the rendered colours match the first snapshot, and there is a single done pulse.
//   6. Assert resetn at pixel 3000 -> plot=0 immediately, busy=0, and no done pulse.
//      After release, a start gives a full 9216-pixel redraw.

Source files
------------

// File: rtl/board_renderer.sv
// Board renderer: sweeps the 96x96 tic-tac-toe grid one pixel per clock into the
// VGA adapter, drawing grid lines, X glyphs (red) and O box glyphs (blue) from a
// snapshot of the nine square registers taken when the redraw is accepted.
module board_renderer #(
    parameter int unsigned CELL_LOG2 = 5,
    parameter int unsigned X0        = 32,
    parameter int unsigned Y0        = 12,
    parameter int unsigned MARGIN    = 4
) (
    input  logic        clock,
    input  logic        resetn,   // asynchronous, active-high
    input  logic        start,
    input  logic [17:0] board,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CELL   = 1 << CELL_LOG2;
    localparam int unsigned CW     = CELL_LOG2 + 2;
    localparam int unsigned LAST   = 3 * CELL - 1;
    localparam int unsigned G_LO   = MARGIN;
    localparam int unsigned G_HI   = CELL - 1 - MARGIN;
    localparam int unsigned DIAG   = CELL - 1;

    typedef logic [CW-1:0]        cnt_t;
    typedef logic [CELL_LOG2-1:0] uv_t;
    typedef logic [CELL_LOG2:0]   sum_t;

    localparam logic [2:0] COL_LINE = 3'b111;
    localparam logic [2:0] COL_X    = 3'b100;
    localparam logic [2:0] COL_O    = 3'b001;
    localparam logic [2:0] COL_BG   = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    cnt_t        px_q, px_d;
    cnt_t        py_q, py_d;
    logic [17:0] snap_q, snap_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  col, row, sym;
    logic [3:0]  idx;
    uv_t         u, v;
    sum_t        uv_diff, uv_sum;
    logic        in_box, on_line, on_x, on_o;
    logic [2:0]  pix_colour;

    // Classify the pixel at the current sweep coordinate.
    always_comb begin
        col      = 2'(px_q >> CELL_LOG2);
        row      = 2'(py_q >> CELL_LOG2);
        u        = px_q[CELL_LOG2-1:0];
        v        = py_q[CELL_LOG2-1:0];
        idx      = 4'(row) * 4'd3 + 4'(col);
        sym      = 2'(snap_q >> {idx, 1'b0});
        uv_diff  = {1'b0, u} - {1'b0, v};
        uv_sum   = {1'b0, u} + {1'b0, v};
        in_box   = (u >= uv_t'(G_LO)) && (u <= uv_t'(G_HI)) &&
                   (v >= uv_t'(G_LO)) && (v <= uv_t'(G_HI));
        on_line  = ((col != 2'd0) && (u == '0)) || ((row != 2'd0) && (v == '0));
        on_x     = (sym == 2'b01) && in_box &&
                   ((uv_diff == '0) || (uv_diff == sum_t'(1)) || (uv_diff == '1) ||
                    (uv_sum == sum_t'(DIAG - 1)) || (uv_sum == sum_t'(DIAG)) ||
                    (uv_sum == sum_t'(DIAG + 1)));
        on_o     = (sym == 2'b10) && in_box &&
                   ((u == uv_t'(G_LO)) || (u == uv_t'(G_HI)) ||
                    (v == uv_t'(G_LO)) || (v == uv_t'(G_HI)));
        pix_colour = COL_BG;
        if (on_line) begin
            pix_colour = COL_LINE;
        end else if (on_x) begin
            pix_colour = COL_X;
        end else if (on_o) begin
            pix_colour = COL_O;
        end
    end

    // Next-state, sweep counters and registered pixel outputs.
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        snap_d   = snap_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = board;
                    px_d    = '0;
                    py_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                x_d      = 8'(X0) + 8'(px_q);
                y_d      = 7'(Y0) + 7'(py_q);
                colour_d = pix_colour;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (px_q == cnt_t'(LAST)) begin
                    px_d = '0;
                    if (py_q == cnt_t'(LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        py_d = py_q + cnt_t'(1);
                    end
                end else begin
                    px_d = px_q + cnt_t'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, snapshot and output registers.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            px_q     <= '0;
            py_q     <= '0;
            snap_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            snap_q   <= snap_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
